// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the ALU datapath interface.
// Accepts decoded instruction fields over a valid/ready request channel,
// drives registered operands/op_code to a combinational ALU, captures the
// result one cycle later and returns it over a valid/ready response channel.
// Optional build macro ALU_ISSUE_PERF_EN adds issue/stall performance counters.
module alu_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_class,
    input  logic [2:0]       req_funct3,
    input  logic             req_funct7b5,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [XLEN-1:0]  alu_srcA,
    output logic [XLEN-1:0]  alu_srcB,
    output logic [3:0]       alu_op_code,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             alu_is_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_result,
    output logic             rsp_taken,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]      perf_issue_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    // branch: result is a branch condition; taken_on_zero selects polarity
    typedef struct packed {
        logic [3:0] op;
        logic       illegal;
        logic       branch;
        logic       taken_on_zero;
    } dec_t;

    // Translate class/funct3/funct7b5 into ALU op_code and branch kind.
    function automatic dec_t decode(input logic [1:0] cls,
                                    input logic [2:0] f3,
                                    input logic       f7b5);
        dec_t d;
        d               = '0;
        d.op            = OP_ADD;
        case (cls)
            2'b00, 2'b01: begin
                case (f3)
                    3'b000:  d.op = (f7b5 && (cls == 2'b00)) ? OP_SUB : OP_ADD;
                    3'b001:  d.op = OP_SLL;
                    3'b010:  d.op = OP_SLT;
                    3'b011:  d.op = OP_SLTU;
                    3'b100:  d.op = OP_XOR;
                    3'b101:  d.op = f7b5 ? OP_SRA : OP_SRL;
                    3'b110:  d.op = OP_OR;
                    default: d.op = OP_AND;
                endcase
            end
            2'b10: begin
                d.branch = 1'b1;
                case (f3)
                    3'b000: begin d.op = OP_SUB;  d.taken_on_zero = 1'b1; end
                    3'b001: begin d.op = OP_SUB;  d.taken_on_zero = 1'b0; end
                    3'b100: begin d.op = OP_SLT;  d.taken_on_zero = 1'b0; end
                    3'b101: begin d.op = OP_SLT;  d.taken_on_zero = 1'b1; end
                    3'b110: begin d.op = OP_SLTU; d.taken_on_zero = 1'b0; end
                    3'b111: begin d.op = OP_SLTU; d.taken_on_zero = 1'b1; end
                    default: begin
                        // undecodable branch: plain ADD, never taken
                        d.op      = OP_ADD;
                        d.illegal = 1'b1;
                        d.branch  = 1'b0;
                    end
                endcase
            end
            default: d.op = OP_ADD;  // MEM address generation
        endcase
        return d;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    dec_t              w_dec;
    logic              w_accept;
    logic              r_branch;
    logic              r_taken_on_zero;
    logic              r_illegal;
    logic [TAG_W-1:0]  r_tag;

    assign w_dec     = decode(req_class, req_funct3, req_funct7b5);
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_state == S_RSP);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and request-ready; req_ready never depends on req_valid.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_RSP;
            end
            S_RSP: begin
                req_ready = rsp_ready;
                if (rsp_ready) w_state_nxt = req_valid ? S_EXEC : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Issue registers: operands and decoded kind latched on acceptance only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_srcA        <= '0;
            alu_srcB        <= '0;
            alu_op_code     <= '0;
            r_branch        <= 1'b0;
            r_taken_on_zero <= 1'b0;
            r_illegal       <= 1'b0;
            r_tag           <= '0;
        end else if (w_accept) begin
            alu_srcA        <= req_a;
            alu_srcB        <= req_b;
            alu_op_code     <= w_dec.op;
            r_branch        <= w_dec.branch;
            r_taken_on_zero <= w_dec.taken_on_zero;
            r_illegal       <= w_dec.illegal;
            r_tag           <= req_tag;
        end
    end

    // Response capture at the end of EXEC; held stable throughout RSP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result  <= '0;
            rsp_taken   <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_tag     <= '0;
        end else if (r_state == S_EXEC) begin
            rsp_result  <= alu_out;
            rsp_taken   <= r_branch && (r_taken_on_zero == alu_is_zero);
            rsp_illegal <= r_illegal;
            rsp_tag     <= r_tag;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    // Performance counters: accepted requests and back-pressured response cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_accept)                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (rsp_valid && !rsp_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU datapath interface.
- Accepts decoded instruction fields and operands over a valid/ready request channel, then translates them into the ALU's 4-bit op_code.
- Drives registered srcA/srcB/op_code to the combinational ALU and captures its result and zero flag one cycle later.
- Resolves the branch condition and returns the result over a valid/ready response channel. Used by the multi-cycle execute stage.

Parameters:
- XLEN, 32, operand/result width; must equal the ALU width.
- TAG_W, 4, width of the opaque request tag echoed on the response.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_class  input  2  00=OP, 01=OP-IMM, 10=BRANCH, 11=MEM address.
- req_funct3  input  3  RISC-V funct3.
- req_funct7b5  input  1  instruction bit 30.
- req_a  input  XLEN  operand A.
- req_b  input  XLEN  operand B (rs2 or immediate).
- req_tag  input  TAG_W  echoed tag.
- alu_srcA  output  XLEN  to ALU srcA.
- alu_srcB  output  XLEN  to ALU srcB.
- alu_op_code  output  4  to ALU op_code.
- alu_out  input  XLEN  from ALU.
- alu_is_zero  input  1  from ALU.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  XLEN  captured alu_out.
- rsp_taken  output  1  branch taken; 0 for non-branch classes.
- rsp_illegal  output  1  undecodable funct3 for the class.
- rsp_tag  output  TAG_W  tag of the request.

Behaviour:
- **Op_code encoding:**
  - ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100.
  - SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001.
- **OP decode by funct3:**
  - 000 → SUB if funct7b5, else ADD.
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
  - 101 → SRA if funct7b5, else SRL.
  - 110 → OR; 111 → AND.
- **OP-IMM:** same as OP, except funct3=000 is always ADD (funct7b5 ignored).
- **BRANCH decode:**
  - 000 BEQ: SUB, taken=is_zero.
  - 001 BNE: SUB, taken=!is_zero.
  - 100 BLT: SLT, taken=!is_zero.
  - 101 BGE: SLT, taken=is_zero.
  - 110 BLTU: SLTU, taken=!is_zero.
  - 111 BGEU: SLTU, taken=is_zero.
  - 010/011: illegal=1, op ADD, taken=0.
- **MEM:** always ADD; funct3 and funct7b5 ignored; illegal=0.
- **FSM states:** IDLE, EXEC, RSP.
  - IDLE: req_ready=1. On handshake, register srcA/srcB/op_code, the decoded branch kind, illegal and tag → EXEC.
  - EXEC: the ALU evaluates the registered inputs. At the edge, capture alu_out into rsp_result, compute rsp_taken from alu_is_zero, set rsp_valid=1 → RSP.
  - RSP: rsp_valid=1; all rsp_* fields stay stable until rsp_ready. req_ready=rsp_ready.
    - rsp_ready && req_valid: retire the response and accept the new request in the same cycle → EXEC, rsp_valid=0.
    - rsp_ready && !req_valid: → IDLE.
- **Latency and throughput:** request handshake at cycle N; rsp_valid rises at cycle N+2. Back-to-back throughput is one request per 2 cycles.
- **Stability:** alu_srcA/alu_srcB/alu_op_code change only on request acceptance and hold their value through EXEC and RSP.
- **Reset** (asynchronous, any state, including mid-EXEC): state=IDLE; all alu_* and rsp_* outputs = 0; rsp_valid=0. A pending response is discarded.
- **Combinational outputs:** req_ready depends only on state and rsp_ready; there is no combinational path from req_valid.

Optional Feature:
- **Macro:** ALU_ISSUE_PERF_EN.
- **Defined:** adds output perf_issue_cnt (32 bits) and output perf_stall_cnt (32 bits).
  - perf_issue_cnt increments on each request handshake.
  - perf_stall_cnt increments on each cycle with rsp_valid && !rsp_ready.
  - Both are reset to 0 by rst_n and wrap from 0xFFFFFFFF to 0.
- **Undefined:** the ports and counters do not exist.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC → next cycle rsp_valid=0, req_ready=1, alu_op_code=0000, rsp_result=0.
- OP SUB: class=00, f3=000, f7b5=1, a=10, b=3, paired with the ALU → op_code=0001 at cycle N+1; rsp_result=7 and rsp_valid=1 at cycle N+2.
- OP-IMM f3=000, f7b5=1, a=5, b=1 → op_code=0000, result=6. OP-IMM f3=101, f7b5=1, a=0x80000000, b=4 → op_code=0111, result=0xF8000000.
- BRANCH BLT a=0xFFFFFFFF, b=1 → op 1000, taken=1. BGEU, same operands → op 1001, taken=1. BEQ a=b=7 → taken=1. BNE a=b=7 → taken=0. f3=010 → illegal=1, taken=0.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp fields stable, req_ready=0. Then raise rsp_ready with req_valid=1 → response retired and new request accepted in the same cycle; next rsp_valid two cycles later; tags 3 then 4 returned in order.
- With ALU_ISSUE_PERF_EN: 3 requests and 5 stall cycles → perf_issue_cnt=3, perf_stall_cnt=5.
